seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial stimulus transmitter for the sequence-detector family. Shifts a loaded bit pattern out on a single serial line `j`, one bit per clock, optionally repeated back-to-back. Alongside the stream it produces golden expected outputs for a Mealy detector and a Moore detector of a parameterised target sequence, so downstream detectors can be checked against them cycle-by-cycle. Sits on the driving side of the detectors, in place of hand-written stimulus.

## Interface
- `PW`, 16: maximum pattern length in bits.
- `TLEN`, 4: target sequence length, 2..PW.
- `TARGET`, 4'b1001: target sequence; MSB is the first bit in time.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  transaction request, sampled only in IDLE.
- `pat_in`  in  PW  pattern; bit `len-1` is transmitted first.
- `len_in`  in  $clog2(PW)+1  pattern length in bits.
- `rep_in`  in  4  extra passes; total passes = `rep_in`+1.
- `j`  out  1  serial data bit (registered).
- `j_valid`  out  1  `j` carries a pattern bit this cycle.
- `busy`  out  1  high in SEND and DONE.
- `done`  out  1  one-cycle completion pulse.
- `expect_mealy`  out  1  golden Mealy detector output.
- `expect_moore`  out  1  golden Moore detector output; equals `expect_mealy` delayed one cycle.

## Operation
- States:
  - IDLE -> SEND when `start`=1 and `len_in`!=0.
  - SEND -> DONE after the last bit of the last pass.
  - DONE -> IDLE unconditionally.
- Accept in IDLE with `start`=1:
  - Latch `pat_in`, `len_in` and `rep_in`.
  - Clamp `len` to `PW` when `len_in`>`PW`.
  - Clear the history register.
- `start` with `len_in`=0 is ignored: state and outputs are unchanged.
- `start` while `busy` is ignored. Inputs are not re-sampled mid-transaction.
- SEND:
  - Each cycle presents the next pattern bit on `j` with `j_valid`=1.
  - A bit counter counts down from `len-1` to 0.
  - At 0 with passes remaining, the counter reloads from the latched copy with no gap cycle; the pattern restarts at bit `len-1`.
- DONE: `j`=0, `j_valid`=0, `done`=1 for exactly one cycle.
- History register (TLEN-1 bits):
  - Shifts in `j` on every cycle where `j_valid`=1.
  - Spans pass boundaries.
  - Is cleared at accept, so matches never span transactions.
- `expect_mealy` = `j_valid` AND ({history, `j`} == `TARGET`). Overlapping matches are detected.
- `expect_moore` is a register of `expect_mealy`. It may be 1 in the DONE cycle, and is 0 in IDLE after that.
- Reset (asynchronous, any state):
  - State -> IDLE.
  - `j`, `j_valid`, `busy`, `done`, `expect_mealy`, `expect_moore`, history, counters and latches all -> 0.
  - Reset mid-transaction abandons the stream with no `done` pulse.

## Timing
- Cycle 0 is the edge that samples `start`. First bit is on `j` from cycle 1.
- Bit k (0-based, across all passes) is valid in cycle 1+k.
- Total bits N = `len`·(`rep_in`+1). DONE (`done`=1) in cycle N+1; IDLE in cycle N+2, where a new `start` can be accepted.
- `busy` is high for cycles 1..N+1.
- `expect_mealy` is valid in the same cycle as the `j` bit that completes the match.
- `expect_moore` follows one cycle later.
- Release of `rst` is not synchronised inside the block; the team drives it synchronously to `clk`.

## Test plan
- Accept `pat_in`=10'b0100101001, `len_in`=10, `rep_in`=0:
  - `j` = 0,1,0,0,1,0,1,0,0,1 in cycles 1..10.
  - `expect_mealy` high in cycles 5 and 10.
  - `expect_moore` high in cycles 6 and 11.
  - `done` in cycle 11.
- Overlap: `pat_in`=7'b1001001, `len_in`=7:
  - `expect_mealy` high in cycles 4 and 7 only.
  - `done` in cycle 8.
- Repeat: `pat_in`=3'b100, `len_in`=3, `rep_in`=2:
  - Stream is 100100100 with no gaps.
  - `expect_mealy` high in cycles 4 and 7, across pass boundaries.
  - `done` in cycle 10.
- Ignore cases:
  - `start` held high during SEND: no restart, and the stream is unchanged.
  - `start` with `len_in`=0: `busy` stays 0.
  - `len_in`=20 with PW=16 sends 16 bits.
- Reset: assert `rst`=0 in cycle 3 of a 10-bit send.
  - All outputs go to 0 immediately, with no `done` pulse.
  - After release, a new transaction runs normally, and history does not carry over (no false match in its first 3 bits).
- Back-to-back: `start` re-asserted in the first IDLE cycle after `done`:
  - Accepted.
  - The first bit appears exactly one cycle later.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
// Bus bundle for seq_pattern_tx: transaction request inputs plus the
// serial stream and golden detector outputs.
interface seq_pattern_tx_if #(
  parameter int PW = 16
) ();
  localparam int LW = $clog2(PW) + 1;

  logic          start;
  logic [PW-1:0] pat_in;
  logic [LW-1:0] len_in;
  logic [3:0]    rep_in;
  logic          j;
  logic          j_valid;
  logic          busy;
  logic          done;
  logic          expect_mealy;
  logic          expect_moore;

  // Stimulus side: issues requests, observes the stream.
  modport master (
    output start, pat_in, len_in, rep_in,
    input  j, j_valid, busy, done, expect_mealy, expect_moore
  );

  // Transmitter side.
  modport slave (
    input  start, pat_in, len_in, rep_in,
    output j, j_valid, busy, done, expect_mealy, expect_moore
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: shifts a latched bit pattern out on j (MSB of the used
// length first), optionally repeating it back-to-back, and produces golden
// Mealy/Moore outputs for a TARGET sequence detector alongside the stream.
// Stage p0 holds the FSM, bit counter and latched request; stage p1 holds
// the registered serial outputs; stage p2 is the Moore delay.
module seq_pattern_tx #(
  parameter int              PW     = 16,
  parameter int              TLEN   = 4,
  parameter logic [TLEN-1:0] TARGET = 4'b1001
) (
  input logic             clk,
  input logic             rst,
  seq_pattern_tx_if.slave bus
);
  localparam int LW = $clog2(PW) + 1;
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_p0;
  state_t          state_nxt;
  logic [PW-1:0]   pat_p0;
  logic [LW-1:0]   len_p0;
  logic [CW-1:0]   cnt_p0;
  logic [3:0]      pass_p0;

  logic            accept;
  logic            last_bit;
  logic            wrap;
  logic [LW-1:0]   len_sat;

  logic            emit;
  logic            bit_nxt;
  logic            busy_nxt;
  logic            done_nxt;
  logic [TLEN-1:0] win;

  logic            j_p1;
  logic            vld_p1;
  logic            busy_p1;
  logic            done_p1;
  logic            mealy_p1;
  logic [TLEN-2:0] hist_p1;
  logic            moore_p2;

  // Lengths beyond the pattern register saturate to its full width.
  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] l);
    if (l > LW'(PW)) return LW'(PW);
    return l;
  endfunction

  // Index of the first bit sent for a given (non-zero) length.
  function automatic logic [CW-1:0] first_idx(input logic [LW-1:0] l);
    logic [LW-1:0] m1;
    m1 = l - LW'(1);
    return m1[CW-1:0];
  endfunction

  // Request qualification and end-of-pass decode.
  always_comb begin
    len_sat  = sat_len(bus.len_in);
    accept   = (state_p0 == IDLE) && bus.start && (bus.len_in != '0);
    last_bit = (cnt_p0 == '0);
    wrap     = last_bit && (pass_p0 != '0);
  end

  // ---- stage p0: FSM state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_p0 <= IDLE;
    else      state_p0 <= state_nxt;
  end

  // FSM next-state: a zero-length request never leaves IDLE.
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (accept) state_nxt = SEND;
      SEND:    if (last_bit && !wrap) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: what the p1 output registers load on the next edge.
  always_comb begin
    emit     = 1'b0;
    bit_nxt  = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_p0)
      SEND: begin
        emit     = 1'b1;
        bit_nxt  = pat_p0[cnt_p0];
        busy_nxt = 1'b1;
      end
      DONE: begin
        busy_nxt = 1'b1;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
    win = {hist_p1, bit_nxt};
  end

  // Request latch, bit counter and pass counter; reload with no gap cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_p0  <= '0;
      len_p0  <= '0;
      cnt_p0  <= '0;
      pass_p0 <= '0;
    end else if (accept) begin
      pat_p0  <= bus.pat_in;
      len_p0  <= len_sat;
      cnt_p0  <= first_idx(len_sat);
      pass_p0 <= bus.rep_in;
    end else if (state_p0 == SEND) begin
      if (!last_bit) begin
        cnt_p0 <= cnt_p0 - CW'(1);
      end else if (wrap) begin
        cnt_p0  <= first_idx(len_p0);
        pass_p0 <= pass_p0 - 4'd1;
      end
    end
  end

  // ---- stage p1: registered stream, history window and Mealy output ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j_p1     <= 1'b0;
      vld_p1   <= 1'b0;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
      mealy_p1 <= 1'b0;
      hist_p1  <= '0;
    end else begin
      j_p1     <= bit_nxt;
      vld_p1   <= emit;
      busy_p1  <= busy_nxt;
      done_p1  <= done_nxt;
      mealy_p1 <= emit && (win == TARGET);
      if (accept)    hist_p1 <= '0;
      else if (emit) hist_p1 <= win[TLEN-2:0];
    end
  end

  // ---- stage p2: Moore output is the Mealy output one cycle later ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) moore_p2 <= 1'b0;
    else      moore_p2 <= mealy_p1;
  end

  assign bus.j            = j_p1;
  assign bus.j_valid      = vld_p1;
  assign bus.busy         = busy_p1;
  assign bus.done         = done_p1;
  assign bus.expect_mealy = mealy_p1;
  assign bus.expect_moore = moore_p2;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed cases plus randomized transactions
// compared cycle-by-cycle against a stream-level reference model.
module tb_seq_pattern_tx;
  localparam int              PW     = 16;
  localparam int              TLEN   = 4;
  localparam logic [TLEN-1:0] TARGET = 4'b1001;
  localparam int              LW     = $clog2(PW) + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hits;
  int   nvld;
  bit   exp_j[$];
  bit   exp_m[$];

  seq_pattern_tx_if #(.PW(PW)) bus ();

  seq_pattern_tx #(.PW(PW), .TLEN(TLEN), .TARGET(TARGET)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input int c, input bit ej, input bit ev, input bit eb,
                            input bit ed, input bit em, input bit emo);
    chk($sformatf("j@%0d", c),     bus.j,            ej);
    chk($sformatf("vld@%0d", c),   bus.j_valid,      ev);
    chk($sformatf("busy@%0d", c),  bus.busy,         eb);
    chk($sformatf("done@%0d", c),  bus.done,         ed);
    chk($sformatf("mealy@%0d", c), bus.expect_mealy, em);
    chk($sformatf("moore@%0d", c), bus.expect_moore, emo);
  endtask

  // Reference: full bit stream of the transaction, then a match wherever the
  // last TLEN bits (zeros before the transaction) spell TARGET.
  task automatic build_model(input logic [PW-1:0] pat, input int len, input int rep);
    int eff;
    logic [TLEN-1:0] tgt;
    tgt = TARGET;
    eff = (len > PW) ? PW : len;
    exp_j.delete();
    exp_m.delete();
    for (int p = 0; p <= rep; p++)
      for (int i = eff - 1; i >= 0; i--)
        exp_j.push_back(pat[i]);
    for (int k = 0; k < exp_j.size(); k++) begin
      bit hit;
      hit = 1'b1;
      for (int i = 0; i < TLEN; i++) begin
        int idx;
        bit b;
        idx = k - TLEN + 1 + i;
        b = (idx < 0) ? 1'b0 : exp_j[idx];
        if (b != tgt[TLEN-1-i]) hit = 1'b0;
      end
      exp_m.push_back(hit);
    end
  endtask

  // Present a request so the next rising edge samples it (cycle 0).
  task automatic launch(input logic [PW-1:0] pat, input int len, input int rep);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.pat_in = pat;
    bus.len_in = LW'(len);
    bus.rep_in = 4'(rep);
    build_model(pat, len, rep);
    @(posedge clk);
    #1;
    check_outs(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check cycles 1..upto; with hold, start stays high and inputs churn.
  task automatic follow(input bit hold, input int upto);
    int n;
    n = exp_j.size();
    hits = 0;
    nvld = 0;
    @(negedge clk);
    if (hold) begin
      bus.pat_in = PW'($urandom);
      bus.len_in = LW'($urandom_range(1, 16));
      bus.rep_in = 4'($urandom_range(0, 15));
    end else begin
      bus.start = 1'b0;
    end
    for (int c = 1; c <= upto; c++) begin
      @(posedge clk);
      #1;
      if (c <= n) begin
        check_outs(c, exp_j[c-1], 1, 1, 0, exp_m[c-1], (c > 1) ? exp_m[c-2] : 1'b0);
      end else begin
        check_outs(c, 0, 0, 1, 1, 0, exp_m[n-1]);
      end
      hits += int'(bus.expect_mealy);
      nvld += int'(bus.j_valid);
      if (hold && c == n) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      check_outs(-1, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] p;
    int            l;
    int            r;
    bit            h;

    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.pat_in = '0;
    bus.len_in = '0;
    bus.rep_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs(-2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Basic 10-bit send, matches at cycles 5 and 10.
    launch(16'b0100101001, 10, 0);
    follow(0, 11);
    chk("hits_basic", hits, 2);
    idle(1);

    // Overlapping matches.
    launch(16'b1001001, 7, 0);
    follow(0, 8);
    chk("hits_overlap", hits, 2);

    // Repeat passes, launched back-to-back with the previous transaction.
    launch(16'b100, 3, 2);
    follow(0, 10);
    chk("hits_repeat", hits, 2);

    // Back-to-back again, start held high through SEND.
    launch(16'hB6D9, 6, 1);
    follow(1, 13);
    idle(1);

    // Zero-length request is ignored.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.len_in = '0;
    bus.pat_in = '1;
    idle(3);
    @(negedge clk);
    bus.start = 1'b0;

    // Over-length request saturates to PW bits.
    launch(16'hA5C3, 20, 0);
    follow(0, 17);
    chk("len20_bits", nvld, 16);
    idle(1);

    // Asynchronous reset in cycle 3 of a 10-bit send.
    launch(16'b0100101001, 10, 0);
    follow(0, 2);
    #3;
    rst = 1'b0;
    #1;
    check_outs(-3, 0, 0, 0, 0, 0, 0);
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    launch(16'b0011001, 7, 0);
    follow(0, 8);
    chk("hits_after_rst", hits, 1);
    idle(1);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      p = PW'($urandom);
      l = $urandom_range(1, 20);
      r = $urandom_range(0, 3);
      h = 1'($urandom_range(0, 1));
      launch(p, l, r);
      follow(h, exp_j.size() + 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
